// File: rtl/seq_div_pkg.sv
// seq_div_pkg
// Shared types and helpers for the sequential divider.
//   div_state_e : divider FSM state (IDLE, CALC, DONE)
//   cnt_width() : width needed for a counter that holds the value WIDTH
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // The bit counter is loaded with WIDTH itself, so it needs room for
   // WIDTH, not just WIDTH-1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_divider_sub.sv
// sub
// Ripple-borrow subtractor: s_o = a_i - b_i - cin_i.
//   a_i, b_i : WIDTH-bit minuend and subtrahend
//   cin_i    : borrow in
//   s_o      : WIDTH-bit difference
//   cout_o   : borrow out (1 means a_i < b_i + cin_i)
module sub #(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] s_o,
   output logic             cout_o
);

   // Walk the borrow from bit 0 upward, one full-subtractor cell per bit.
   always_comb begin
      logic borrow;
      borrow = cin_i;
      s_o    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ borrow;
         borrow = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow);
      end
      cout_o = borrow;
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Multi-cycle unsigned restoring divider producing one quotient bit per
// cycle through a single shared WIDTH+1 bit subtractor.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operation handshake (dividend, divisor)
//   out_valid / out_ready : result handshake (quotient, remainder,
//                           div_by_zero)
// Optional build macro SEQ_DIV_SIGNED_EN adds the is_signed input, which
// selects truncating signed division for that operation.
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
   input  logic             is_signed,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CntW = cnt_width(WIDTH);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             dbz_q, dbz_d;
   logic             negQuo_q, negQuo_d;
   logic             negRem_q, negRem_d;

   logic [WIDTH-1:0] dividendMag;
   logic [WIDTH-1:0] divisorMag;
   logic             dividendNeg;
   logic             divisorNeg;
   logic [WIDTH:0]   trialP;
   logic [WIDTH:0]   subDiff;
   logic             subBorrow;
   logic             unusedDiffMsb;

   // Operand conditioning at accept: in signed mode the core only ever sees
   // magnitudes, and the signs are remembered for the final fix-up.
`ifdef SEQ_DIV_SIGNED_EN
   assign dividendNeg = is_signed & dividend[WIDTH-1];
   assign divisorNeg  = is_signed & divisor[WIDTH-1];
   assign dividendMag = dividendNeg ? (~dividend + 1'b1) : dividend;
   assign divisorMag  = divisorNeg  ? (~divisor  + 1'b1) : divisor;
`else
   assign dividendNeg = 1'b0;
   assign divisorNeg  = 1'b0;
   assign dividendMag = dividend;
   assign divisorMag  = divisor;
`endif

   // Partial remainder with the next dividend bit shifted in. One extra bit
   // keeps 2*R+1 from overflowing before the trial subtraction.
   assign trialP = {rem_q, quo_q[WIDTH-1]};

   sub #(
      .WIDTH (WIDTH + 1)
   ) u_sub (
      .a_i    (trialP),
      .b_i    ({1'b0, div_q}),
      .cin_i  (1'b0),
      .s_o    (subDiff),
      .cout_o (subBorrow)
   );

   // A successful trial always leaves a difference below the divisor, so
   // the top difference bit carries no information.
   assign unusedDiffMsb = subDiff[WIDTH];

   // State and datapath registers; reset drops back to IDLE at once and
   // throws away any result in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         quo_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         dbz_q    <= 1'b0;
         negQuo_q <= 1'b0;
         negRem_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         dbz_q    <= dbz_d;
         negQuo_q <= negQuo_d;
         negRem_q <= negRem_d;
      end
   end

   // Next-state and handshake logic. IDLE loads the operands (or resolves a
   // zero divisor immediately), CALC retires one quotient bit per cycle, and
   // DONE holds the result until the consumer takes it.
   always_comb begin
      state_d   = state_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      dbz_d     = dbz_q;
      negQuo_d  = negQuo_q;
      negRem_d  = negRem_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               div_d = divisorMag;
               cnt_d = CntW'(WIDTH);
               if (divisor == '0) begin
                  quo_d    = '1;
                  rem_d    = dividend;
                  dbz_d    = 1'b1;
                  negQuo_d = 1'b0;
                  negRem_d = 1'b0;
                  state_d  = DONE;
               end else begin
                  quo_d    = dividendMag;
                  rem_d    = '0;
                  dbz_d    = 1'b0;
                  negQuo_d = dividendNeg ^ divisorNeg;
                  negRem_d = dividendNeg;
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q - 1'b1;
            if (subBorrow) begin
               rem_d = trialP[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
               rem_d = subDiff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
            if (cnt_q == CntW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Results are only presented in DONE; the sign fix-up is applied on the
   // way out so the core registers stay pure magnitudes.
   always_comb begin
      quotient    = '0;
      remainder   = '0;
      div_by_zero = 1'b0;
      if (state_q == DONE) begin
         quotient    = negQuo_q ? (~quo_q + 1'b1) : quo_q;
         remainder   = negRem_q ? (~rem_q + 1'b1) : rem_q;
         div_by_zero = dbz_q;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Directed bench for seq_divider at WIDTH=8: basic division and latency,
// edge operands, divide by zero, backpressure, reset mid-operation and,
// when SEQ_DIV_SIGNED_EN is defined, signed division.
module tb_seq_divider;

   localparam int WIDTH = 8;
   localparam int WaitBudget = 40;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIV_SIGNED_EN
   logic             isSigned;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int testsRun;
   int testsFailed;

   seq_divider #(
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef SEQ_DIV_SIGNED_EN
      .is_signed   (isSigned),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one operation for exactly one accepting edge, then return 1
   // unit after that edge with in_valid already dropped.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic sgn);
      @(negedge clk);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
      isSigned = sgn;
`else
      if (sgn) $display("[TB] signed request ignored in unsigned build");
`endif
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count edges after the accept until out_valid is seen, bounded.
   task automatic waitForResult(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < WaitBudget) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   // Complete the result handshake on one edge.
   task automatic takeResult();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      testsRun++;
      if (in_ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready);
      end
      testsRun++;
      if (out_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid);
      end
      testsRun++;
      if ({quotient, remainder, div_by_zero} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs got q=%0d r=%0d dbz=%0b want 0/0/0",
                  quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int cycles;
      applyStimulus(8'd100, 8'd7, 1'b0);
      testsRun++;
      if (in_ready !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL basic_busy_in_ready got %0b want 0", in_ready);
      end
      waitForResult(cycles);
      testsRun++;
      if (cycles !== 8) begin
         testsFailed++;
         $display("[TB] FAIL basic_latency got %0d want 8", cycles);
      end
      testsRun++;
      if ({out_valid, quotient, remainder, div_by_zero} !== {1'b1, 8'd14, 8'd2, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL basic_100_7 got v=%0b q=%0d r=%0d dbz=%0b want 1/14/2/0",
                  out_valid, quotient, remainder, div_by_zero);
      end
      takeResult();
   endtask

   task automatic test_patterns();
      int cycles;
      applyStimulus(8'd255, 8'd1, 1'b0);
      waitForResult(cycles);
      testsRun++;
      if ({out_valid, quotient, remainder} !== {1'b1, 8'd255, 8'd0}) begin
         testsFailed++;
         $display("[TB] FAIL pat_255_1 got v=%0b q=%0d r=%0d want 1/255/0",
                  out_valid, quotient, remainder);
      end
      takeResult();
      applyStimulus(8'd5, 8'd9, 1'b0);
      waitForResult(cycles);
      testsRun++;
      if ({out_valid, quotient, remainder} !== {1'b1, 8'd0, 8'd5}) begin
         testsFailed++;
         $display("[TB] FAIL pat_5_9 got v=%0b q=%0d r=%0d want 1/0/5",
                  out_valid, quotient, remainder);
      end
      takeResult();
   endtask

   task automatic test_div_zero();
      int cycles;
      applyStimulus(8'd42, 8'd0, 1'b0);
      // The result is already up in the cycle right after the accept edge.
      testsRun++;
      if (out_valid !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL dbz_latency out_valid got %0b want 1", out_valid);
      end
      waitForResult(cycles);
      testsRun++;
      if ({quotient, remainder, div_by_zero} !== {8'hFF, 8'd42, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL dbz_42_0 got q=%0h r=%0d dbz=%0b want ff/42/1",
                  quotient, remainder, div_by_zero);
      end
      takeResult();
   endtask

   task automatic test_back_to_back();
      int cycles;
      int holdBad;
      applyStimulus(8'd200, 8'd3, 1'b0);
      waitForResult(cycles);
      holdBad = 0;
      // Consumer stalls; meanwhile a new request is offered and must be ignored.
      in_valid = 1'b1;
      dividend = 8'd1;
      divisor  = 8'd1;
      for (int i = 0; i < 5; i++) begin
         if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, 8'd66, 8'd2})
            holdBad++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      testsRun++;
      if (holdBad !== 0) begin
         testsFailed++;
         $display("[TB] FAIL bp_hold bad cycles got %0d want 0 (last q=%0d r=%0d)",
                  holdBad, quotient, remainder);
      end
      testsRun++;
      if ({out_valid, quotient, remainder} !== {1'b1, 8'd66, 8'd2}) begin
         testsFailed++;
         $display("[TB] FAIL bp_200_3 got v=%0b q=%0d r=%0d want 1/66/2",
                  out_valid, quotient, remainder);
      end
      takeResult();
      testsRun++;
      if ({in_ready, out_valid} !== 2'b10) begin
         testsFailed++;
         $display("[TB] FAIL bp_after_handshake got in_ready=%0b out_valid=%0b want 1/0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_calc();
      int cycles;
      int sawValid;
      applyStimulus(8'd100, 8'd7, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      testsRun++;
      if ({out_valid, in_ready} !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_async got out_valid=%0b in_ready=%0b want 0/1",
                  out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sawValid = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) sawValid++;
      end
      testsRun++;
      if (sawValid !== 0 || in_ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_discard got valid_cycles=%0d in_ready=%0b want 0/1",
                  sawValid, in_ready);
      end
      applyStimulus(8'd9, 8'd4, 1'b0);
      waitForResult(cycles);
      testsRun++;
      if ({out_valid, quotient, remainder} !== {1'b1, 8'd2, 8'd1}) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_9_4 got v=%0b q=%0d r=%0d want 1/2/1",
                  out_valid, quotient, remainder);
      end
      takeResult();
   endtask

`ifdef SEQ_DIV_SIGNED_EN
   task automatic test_signed();
      int cycles;
      applyStimulus(8'hF9, 8'd2, 1'b1);
      waitForResult(cycles);
      testsRun++;
      if ({out_valid, quotient, remainder} !== {1'b1, 8'hFD, 8'hFF}) begin
         testsFailed++;
         $display("[TB] FAIL signed_m7_2 got v=%0b q=%0h r=%0h want 1/fd/ff",
                  out_valid, quotient, remainder);
      end
      takeResult();
      applyStimulus(8'h80, 8'hFF, 1'b1);
      waitForResult(cycles);
      testsRun++;
      if (cycles !== 8 || {out_valid, quotient, remainder} !== {1'b1, 8'h80, 8'h00}) begin
         testsFailed++;
         $display("[TB] FAIL signed_min_m1 got lat=%0d v=%0b q=%0h r=%0h want 8/1/80/00",
                  cycles, out_valid, quotient, remainder);
      end
      takeResult();
   endtask
`endif

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      dividend    = '0;
      divisor     = '0;
`ifdef SEQ_DIV_SIGNED_EN
      isSigned    = 1'b0;
`endif
      test_reset();
      test_basic();
      test_patterns();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_calc();
`ifdef SEQ_DIV_SIGNED_EN
      test_signed();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
